// File: rtl/inv_mix_columns_seq_pkg.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_seq_pkg : shared AES widths, FSM state type, GF(2^8) xtime
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package inv_mix_columns_seq_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inv_mix_columns_seq_inv_mix_column.sv
// ---------------------------------------------------------------------------
// inv_mix_column : combinational AES InvMixColumn on one 32-bit column
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inv_mix_column
  import inv_mix_columns_seq_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [BYTE_W-1:0] w_m9  [4];
  logic [BYTE_W-1:0] w_m11 [4];
  logic [BYTE_W-1:0] w_m13 [4];
  logic [BYTE_W-1:0] w_m14 [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    logic [BYTE_W-1:0] w_a;
    logic [BYTE_W-1:0] w_x2;
    logic [BYTE_W-1:0] w_x4;
    logic [BYTE_W-1:0] w_x8;

    // Byte 0 is the most significant byte of the column
    assign w_a  = col_i[COL_W-1-BYTE_W*i -: BYTE_W];
    assign w_x2 = gf_xtime(w_a);
    assign w_x4 = gf_xtime(w_x2);
    assign w_x8 = gf_xtime(w_x4);

    assign w_m9[i]  = w_x8 ^ w_a;
    assign w_m11[i] = w_x8 ^ w_x2 ^ w_a;
    assign w_m13[i] = w_x8 ^ w_x4 ^ w_a;
    assign w_m14[i] = w_x8 ^ w_x4 ^ w_x2;
  end

  assign col_o = {w_m14[0] ^ w_m11[1] ^ w_m13[2] ^ w_m9[3],
                  w_m9[0]  ^ w_m14[1] ^ w_m11[2] ^ w_m13[3],
                  w_m13[0] ^ w_m9[1]  ^ w_m14[2] ^ w_m11[3],
                  w_m11[0] ^ w_m13[1] ^ w_m9[2]  ^ w_m14[3]};

endmodule

`default_nettype wire

// File: rtl/inv_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_seq : column-serial AES InvMixColumns, one column per clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inv_mix_columns_seq
  import inv_mix_columns_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  state_e             state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [COL_W-1:0]   w_col_in;
  logic [COL_W-1:0]   w_col_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = RUN;
      RUN:     if (col_q == 2'd3) state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Column 0 occupies the top 32 bits of the state
  always_comb begin
    w_col_in = work_q[127:96];
    case (col_q)
      2'd0: w_col_in = work_q[127:96];
      2'd1: w_col_in = work_q[95:64];
      2'd2: w_col_in = work_q[63:32];
      2'd3: w_col_in = work_q[31:0];
      default: w_col_in = work_q[127:96];
    endcase
  end

  inv_mix_column u_col (
    .col_i (w_col_in),
    .col_o (w_col_out)
  );

  always_comb begin
    work_d = work_q;
    col_d  = col_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = in_state;
          col_d  = 2'd0;
        end
      end
      RUN: begin
        case (col_q)
          2'd0: work_d[127:96] = w_col_out;
          2'd1: work_d[95:64]  = w_col_out;
          2'd2: work_d[63:32]  = w_col_out;
          2'd3: work_d[31:0]   = w_col_out;
          default: work_d = work_q;
        endcase
        col_d = col_q + 2'd1;
      end
      default: begin
        work_d = work_q;
        col_d  = col_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q  <= 2'd0;
      work_q <= '0;
    end else begin
      col_q  <= col_d;
      work_q <= work_d;
    end
  end

  assign out_state = work_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_columns_seq : directed and randomized checks of inv_mix_columns_seq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // First row of the circulant matrix; row r is rotated right by r
  function automatic logic [7:0] coef(input bit inv, input int d);
    case (d)
      0: return inv ? 8'd14 : 8'd2;
      1: return inv ? 8'd11 : 8'd3;
      2: return inv ? 8'd13 : 8'd1;
      default: return inv ? 8'd9 : 8'd1;
    endcase
  endfunction

  function automatic logic [127:0] mix_ref(input bit inv, input logic [127:0] s);
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        logic [7:0] acc = 8'h00;
        for (int i = 0; i < 4; i++)
          acc = acc ^ gmul(coef(inv, (i - row + 4) % 4), s[127-8*(4*c+i) -: 8]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128;
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present s until accepted; afterwards in_state is scrambled
  task automatic send(input logic [127:0] s);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    check("send_timeout", {127'b0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_state = s;
    tick;
    in_valid = 1'b0;
    in_state = rand128();
  endtask

  // Wait for a result, stall for 'stall' cycles, then take it
  task automatic collect(input string tag, input logic [127:0] exp, input int stall);
    int n = 0;
    logic [127:0] held;
    out_ready = 1'b0;
    while (!out_valid && n < 20) begin
      check({tag, "_ready_excl"}, {127'b0, in_ready & out_valid}, 128'd0);
      tick;
      n++;
    end
    check({tag, "_valid_timeout"}, {127'b0, out_valid}, 128'd1);
    held = out_state;
    check({tag, "_data"}, out_state, exp);
    for (int k = 0; k < stall; k++) begin
      tick;
      check({tag, "_stall_state"}, {out_state, out_valid, in_ready} , {held, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_after_xfer"}, {126'b0, out_valid, in_ready}, 128'd1);
  endtask

  initial begin
    logic [127:0] s;
    logic [127:0] fips_in  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    logic [127:0] fips_out = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    int lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    tick;
    tick;
    rst_n = 1'b1;
    check("reset_in_ready",  {127'b0, in_ready},  128'd1);
    check("reset_out_valid", {127'b0, out_valid}, 128'd0);
    check("reset_out_state", out_state, 128'd0);

    // FIPS-197 vector with latency measurement, out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = fips_in;
    tick;
    in_valid = 1'b0;
    in_state = rand128();
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    check("fips_latency", 128'(lat), 128'd4);
    check("fips_data", out_state, fips_out);
    check("fips_model", mix_ref(1'b1, fips_in), fips_out);
    tick;
    out_ready = 1'b0;
    check("fips_in_ready_next", {126'b0, out_valid, in_ready}, 128'd1);

    // Zero and the uniform-column fixed point
    send(128'd0);
    collect("zero", 128'd0, 0);
    send({4{32'hc6c6c6c6}});
    collect("c6", {4{32'hc6c6c6c6}}, 0);

    // Backpressure for 10 cycles
    s = rand128();
    send(s);
    collect("bp", mix_ref(1'b1, s), 10);

    // Busy input: in_valid/in_state wiggle during RUN
    s = rand128();
    send(s);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'($urandom);
      in_state = rand128();
      check("busy_in_ready", {127'b0, in_ready}, 128'd0);
      tick;
    end
    in_valid = 1'b0;
    collect("busy", mix_ref(1'b1, s), 2);

    // Reset while col==2
    send(rand128());
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("mid_rst_state", {out_state, out_valid, in_ready}, {128'd0, 1'b0, 1'b1});
    for (int k = 0; k < 6; k++) begin
      tick;
      check("mid_rst_quiet", {127'b0, out_valid}, 128'd0);
    end
    s = rand128();
    send(s);
    collect("post_rst", mix_ref(1'b1, s), 1);

    // Randomized back-to-back with random stalls
    for (int t = 0; t < 1000; t++) begin
      s = rand128();
      send(s);
      collect("rand", mix_ref(1'b1, s), int'($urandom_range(0, 3)));
      check("rand_fwd", mix_ref(1'b0, mix_ref(1'b1, s)), s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
